// File: rtl/change_dispenser.sv
// Change dispenser: drains a loaded amount as a stream of value-2/value-1 coins over ready/valid.
// Optional feature: define CHANGE_ABORT_EN to add an `abort` input that ends a payout early.
module change_dispenser #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] amount,
`ifdef CHANGE_ABORT_EN
    input  logic         abort,
`endif
    input  logic         coin_ready,
    output logic         coin_valid,
    output logic         coin_big,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] remaining,
    output logic [N-1:0] paid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] remaining_q, remaining_d;
    logic [N-1:0] paid_q, paid_d;
    logic [N-1:0] coin_value;
    logic         transfer;
    logic         leave_dispense;

    // Coin size depends only on the registered balance, so it cannot change
    // while the eject mechanism stalls.
    assign coin_valid = (state_q == DISPENSE);
    assign busy       = (state_q == DISPENSE);
    assign done       = (state_q == DONE);
    assign coin_big   = (state_q == DISPENSE) && (remaining_q >= N'(2));
    assign coin_value = coin_big ? N'(2) : N'(1);
    assign transfer   = coin_valid && coin_ready;
    assign remaining  = remaining_q;
    assign paid       = paid_q;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        paid_d         = paid_q;
        leave_dispense = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    paid_d = '0;
                    if (amount != '0) begin
                        remaining_d = amount;
                        state_d     = DISPENSE;
                    end else begin
                        state_d     = DONE;
                    end
                end
            end

            DISPENSE: begin
                if (transfer) begin
                    remaining_d = remaining_q - coin_value;
                    paid_d      = paid_q + coin_value;
                    if (remaining_q == coin_value)
                        leave_dispense = 1'b1;
                end
`ifdef CHANGE_ABORT_EN
                // An abort coinciding with a transfer still books that coin.
                if (abort)
                    leave_dispense = 1'b1;
`endif
                if (leave_dispense)
                    state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above; the async reset clears all
    // of it, which also withdraws any coin on offer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            paid_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; covers the abort path when CHANGE_ABORT_EN is defined.
module tb_change_dispenser;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] amount;
`ifdef CHANGE_ABORT_EN
    logic         abort;
`endif
    logic         coin_ready;
    logic         coin_valid;
    logic         coin_big;
    logic         busy;
    logic         done;
    logic [N-1:0] remaining;
    logic [N-1:0] paid;

    int errors = 0;
    int checks = 0;

    change_dispenser #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amount     (amount),
`ifdef CHANGE_ABORT_EN
        .abort      (abort),
`endif
        .coin_ready (coin_ready),
        .coin_valid (coin_valid),
        .coin_big   (coin_big),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .paid       (paid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output snapshot: valid, big, busy, done, remaining, paid.
    task automatic expect_out(input string tag, input int v, input int b, input int bz,
                              input int d, input int rem, input int pd);
        check({tag, ".coin_valid"}, 32'(coin_valid), v);
        check({tag, ".coin_big"},   32'(coin_big),   b);
        check({tag, ".busy"},       32'(busy),       bz);
        check({tag, ".done"},       32'(done),       d);
        check({tag, ".remaining"},  32'(remaining),  rem);
        check({tag, ".paid"},       32'(paid),       pd);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        amount     = '0;
        coin_ready = 1'b1;
`ifdef CHANGE_ABORT_EN
        abort      = 1'b0;
`endif
        #3;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        expect_out("idle_after_reset", 0, 0, 0, 0, 0, 0);

        // 1: amount=5, ready high -> coins 2,2,1 then done.
        start = 1'b1; amount = 4'd5;
        tick();
        start = 1'b0; amount = '0;
        expect_out("t1.c1", 1, 1, 1, 0, 5, 0);
        tick();
        expect_out("t1.c2", 1, 1, 1, 0, 3, 2);
        tick();
        expect_out("t1.c3", 1, 0, 1, 0, 1, 4);
        tick();
        expect_out("t1.done", 0, 0, 0, 1, 0, 5);
        tick();
        expect_out("t1.idle", 0, 0, 0, 0, 0, 5);

        // 2: amount=0 -> straight to DONE, no coin.
        start = 1'b1; amount = 4'd0;
        tick();
        start = 1'b0;
        expect_out("t2.done", 0, 0, 0, 1, 0, 0);
        tick();
        expect_out("t2.idle", 0, 0, 0, 0, 0, 0);

        // 3: amount=3 with ready stalled four cycles.
        coin_ready = 1'b0;
        start = 1'b1; amount = 4'd3;
        tick();
        start = 1'b0; amount = '0;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("t3.stall%0d", i), 1, 1, 1, 0, 3, 0);
            if (i < 3) tick();
        end
        coin_ready = 1'b1;
        tick();
        expect_out("t3.c2", 1, 0, 1, 0, 1, 2);
        tick();
        expect_out("t3.done", 0, 0, 0, 1, 0, 3);
        tick();

        // 4: amount=6, start with amount=9 mid-run is ignored.
        start = 1'b1; amount = 4'd6;
        tick();
        expect_out("t4.c1", 1, 1, 1, 0, 6, 0);
        amount = 4'd9;
        tick();
        expect_out("t4.c2", 1, 1, 1, 0, 4, 2);
        tick();
        expect_out("t4.c3", 1, 1, 1, 0, 2, 4);
        tick();
        start = 1'b0; amount = '0;
        expect_out("t4.done", 0, 0, 0, 1, 0, 6);
        tick();
        expect_out("t4.idle", 0, 0, 0, 0, 0, 6);

        // 5: amount=7, async reset after two transfers.
        start = 1'b1; amount = 4'd7;
        tick();
        start = 1'b0; amount = '0;
        tick();
        tick();
        expect_out("t5.pre", 1, 1, 1, 0, 3, 4);
        #2;
        rst = 1'b0;
        #1;
        expect_out("t5.in_reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        expect_out("t5.after1", 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("t5.after2", 0, 0, 0, 0, 0, 0);

`ifdef CHANGE_ABORT_EN
        // 6: amount=7, abort coincides with the second transfer.
        start = 1'b1; amount = 4'd7;
        tick();
        start = 1'b0; amount = '0;
        expect_out("t6.c1", 1, 1, 1, 0, 7, 0);
        tick();
        expect_out("t6.c2", 1, 1, 1, 0, 5, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("t6.done", 0, 0, 0, 1, 3, 4);
        tick();
        expect_out("t6.idle", 0, 0, 0, 0, 3, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
